// File: rtl/i2c_xfer_sequencer.sv
// rtl/i2c_xfer_sequencer.sv - APB master sequencing single-byte I2C register transactions
module i2c_xfer_sequencer #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter logic [15:0] PRESCALE       = 16'd99,
  parameter int          POLL_LIMIT     = 1024
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rnw,
  input  logic [6:0]                req_dev,
  input  logic [7:0]                req_reg,
  input  logic [7:0]                req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [7:0]                rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  localparam logic [APB_ADDR_WIDTH-1:0] A_PRE    = APB_ADDR_WIDTH'(8'h00);
  localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL   = APB_ADDR_WIDTH'(8'h04);
  localparam logic [APB_ADDR_WIDTH-1:0] A_TX     = APB_ADDR_WIDTH'(8'h08);
  localparam logic [APB_ADDR_WIDTH-1:0] A_RX     = APB_ADDR_WIDTH'(8'h0C);
  localparam logic [APB_ADDR_WIDTH-1:0] A_CMD    = APB_ADDR_WIDTH'(8'h10);
  localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'(8'h14);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_AL   = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  typedef enum logic [3:0] {
    INIT_PRE, INIT_CTRL, IDLE, WR_TX, WR_CMD, POLL, CLR_IF, STOP, RD_RX, RESP
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  step_q, step_d;
  logic [PCW-1:0]              poll_cnt_q, poll_cnt_d;
  logic                        rnw_q, rnw_d;
  logic [6:0]                  dev_q, dev_d;
  logic [7:0]                  reg_q, reg_d;
  logic [7:0]                  wdata_q, wdata_d;
  logic [1:0]                  err_q, err_d;
  logic [7:0]                  rdata_q, rdata_d;
  logic                        req_ready_q, req_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        psel_q, psel_d;
  logic                        penable_q, penable_d;
  logic                        pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [15:0]                 pwdata_q, pwdata_d;

  logic [7:0] tx_byte;
  logic [7:0] cmd_byte;
  logic       last_step;
  logic       unused_prdata;

  assign unused_prdata = ^{PRDATA[31:8], PRDATA[6], PRDATA[4:1]};

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = {16'h0000, pwdata_q};
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;

  // Per-step TX byte and command; step 3 exists only for reads (RD+NACK+STO, no TX)
  always_comb begin
    tx_byte  = 8'h00;
    cmd_byte = 8'h90;
    case (step_q)
      2'd0: begin
        tx_byte  = {dev_q, 1'b0};
        cmd_byte = 8'h90;
      end
      2'd1: begin
        tx_byte  = reg_q;
        cmd_byte = 8'h10;
      end
      2'd2: begin
        tx_byte  = rnw_q ? {dev_q, 1'b1} : wdata_q;
        cmd_byte = rnw_q ? 8'h90 : 8'h50;
      end
      default: begin
        tx_byte  = 8'h00;
        cmd_byte = 8'h68;
      end
    endcase
    last_step = rnw_q ? (step_q == 2'd3) : (step_q == 2'd2);
  end

  // Next-state: IDLE/RESP handshakes, else APB phases (gap -> setup -> access until PREADY)
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    poll_cnt_d  = poll_cnt_q;
    rnw_d       = rnw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    if (state_q == IDLE) begin
      if (req_valid && req_ready_q) begin
        rnw_d       = req_rnw;
        dev_d       = req_dev;
        reg_d       = req_reg;
        wdata_d     = req_wdata;
        step_d      = 2'd0;
        err_d       = ERR_OK;
        rdata_d     = 8'h00;
        req_ready_d = 1'b0;
        state_d     = WR_TX;
      end
    end else if (state_q == RESP) begin
      if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        rdata_d     = 8'h00;
        err_d       = ERR_OK;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    end else if (!psel_q) begin
      // Idle bus cycle: launch the SETUP phase of this state's transfer
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwdata_d  = 16'h0000;
      case (state_q)
        INIT_PRE:  begin pwrite_d = 1'b1; paddr_d = A_PRE;    pwdata_d = PRESCALE;                   end
        INIT_CTRL: begin pwrite_d = 1'b1; paddr_d = A_CTRL;   pwdata_d = 16'h0080;                   end
        WR_TX:     begin pwrite_d = 1'b1; paddr_d = A_TX;     pwdata_d = {8'h00, tx_byte};           end
        WR_CMD:    begin pwrite_d = 1'b1; paddr_d = A_CMD;    pwdata_d = {8'h00, cmd_byte | 8'h01};  end
        POLL:      begin pwrite_d = 1'b0; paddr_d = A_STATUS;                                        end
        CLR_IF:    begin pwrite_d = 1'b1; paddr_d = A_CMD;    pwdata_d = 16'h0001;                   end
        STOP:      begin pwrite_d = 1'b1; paddr_d = A_CMD;    pwdata_d = 16'h0041;                   end
        RD_RX:     begin pwrite_d = 1'b0; paddr_d = A_RX;                                            end
        default:   psel_d = 1'b0;
      endcase
    end else if (!penable_q) begin
      penable_d = 1'b1;
    end else if (PREADY) begin
      // Transfer completes this cycle; PRDATA is valid here
      psel_d    = 1'b0;
      penable_d = 1'b0;
      case (state_q)
        INIT_PRE:  state_d = INIT_CTRL;
        INIT_CTRL: begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
        WR_TX:     state_d = WR_CMD;
        WR_CMD: begin
          state_d    = POLL;
          poll_cnt_d = '0;
        end
        POLL: begin
          if (PRDATA[0]) begin
            if (err_q == ERR_NACK) begin
              state_d = CLR_IF;
            end else if (PRDATA[5]) begin
              err_d   = ERR_AL;
              state_d = CLR_IF;
            end else if ((step_q != 2'd3) && PRDATA[7]) begin
              err_d   = ERR_NACK;
              state_d = STOP;
            end else begin
              state_d = CLR_IF;
            end
          end else if (poll_cnt_q == POLL_LAST) begin
            err_d   = ERR_TO;
            state_d = STOP;
          end else begin
            poll_cnt_d = poll_cnt_q + PCW'(1);
          end
        end
        CLR_IF: begin
          if (err_q != ERR_OK) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else if (last_step) begin
            if (rnw_q) begin
              state_d = RD_RX;
            end else begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
            end
          end else begin
            step_d  = step_q + 2'd1;
            state_d = (rnw_q && (step_q == 2'd2)) ? WR_CMD : WR_TX;
          end
        end
        STOP: begin
          if (err_q == ERR_TO) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d    = POLL;
            poll_cnt_d = '0;
          end
        end
        RD_RX: begin
          rdata_d     = PRDATA[7:0];
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and registered outputs; reset abandons any transfer and restarts init
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= INIT_PRE;
      step_q      <= 2'd0;
      poll_cnt_q  <= '0;
      rnw_q       <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      err_q       <= ERR_OK;
      rdata_q     <= 8'h00;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      poll_cnt_q  <= poll_cnt_d;
      rnw_q       <= rnw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb/tb_i2c_xfer_sequencer.sv - scoreboard bench for i2c_xfer_sequencer
module tb_i2c_xfer_sequencer;

  logic        HCLK;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_rnw;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
  } apb_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic [1:0] err;
  } rsp_t;

  apb_t       exp_apb[$];
  rsp_t       exp_rsp[$];
  logic [7:0] status_q[$];
  logic [7:0] status_dflt;
  logic [7:0] rx_val;
  apb_t       apb_e;
  rsp_t       rsp_e;

  int checks;
  int errors;
  int apb_done;
  int acc_len;
  int max_acc;
  int stall_cnt;
  int rsp_cnt;
  int rsp_base;

  i2c_xfer_sequencer #(
    .APB_ADDR_WIDTH(12),
    .PRESCALE(16'd99),
    .POLL_LIMIT(4)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic exp_w(input logic [11:0] a, input logic [31:0] d);
    exp_apb.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_r(input logic [11:0] a);
    exp_apb.push_back('{wr: 1'b0, addr: a, data: 32'h0});
  endtask

  // One byte step with IF found on the first poll: [TX], CMD, STATUS, CMD=IACK
  task automatic exp_step(input logic has_tx, input logic [7:0] tx, input logic [7:0] cmdw);
    if (has_tx) exp_w(12'h008, {24'h0, tx});
    exp_w(12'h010, {24'h0, cmdw});
    exp_r(12'h014);
    exp_w(12'h010, 32'h0000_0001);
  endtask

  // APB slave model plus transfer monitor; acts on the falling edge
  always @(negedge HCLK) begin
    if (HRESETn && PSEL && PENABLE) begin
      acc_len++;
      if (stall_cnt > 0) begin
        PREADY = 1'b0;
        stall_cnt--;
      end else begin
        PREADY = 1'b1;
        if (PADDR == 12'h014) PRDATA = {24'h0, (status_q.size() > 0) ? status_q[0] : status_dflt};
        else if (PADDR == 12'h00C) PRDATA = {24'h0, rx_val};
        else PRDATA = 32'h0;
        if (acc_len > max_acc) max_acc = acc_len;
        acc_len = 0;
        apb_done++;
        if (!PWRITE && PADDR == 12'h014 && status_q.size() > 0) void'(status_q.pop_front());
        if (exp_apb.size() == 0) begin
          chk("apb_unexpected", {1'b1, PWRITE, PADDR, PWDATA}, 64'h0);
        end else begin
          apb_e = exp_apb.pop_front();
          chk("apb_xfer", {PWRITE, PADDR, apb_e.wr ? PWDATA : 32'h0},
              {apb_e.wr, apb_e.addr, apb_e.data});
        end
      end
    end else begin
      PREADY = 1'b1;
      PRDATA = 32'h0;
    end
  end

  // Response monitor
  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", {1'b1, rsp_rdata, rsp_err}, 64'h0);
      end else begin
        rsp_e = exp_rsp.pop_front();
        chk("rsp", 64'({rsp_rdata, rsp_err}), 64'(rsp_e));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 500) begin
      @(posedge HCLK); #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'h1);
  endtask

  task automatic do_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
    rsp_base = rsp_cnt;
    wait_ready();
    req_valid = 1'b1;
    req_rnw   = rnw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdata = wd;
    @(posedge HCLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (rsp_cnt == rsp_base && n < 3000) begin
      @(posedge HCLK); #1;
      n++;
    end
    if (rsp_cnt == rsp_base) chk({name, "_rsp_timeout"}, 64'(rsp_cnt), 64'(rsp_base + 1));
    chk({name, "_apb_drained"}, 64'(exp_apb.size()), 64'h0);
  endtask

  task automatic reset_outputs_zero(input string name);
    chk(name, {PSEL, PENABLE, PWRITE, req_ready, rsp_valid, rsp_err, rsp_rdata, PADDR, PWDATA}, 64'h0);
  endtask

  initial begin
    checks = 0; errors = 0; apb_done = 0; acc_len = 0; max_acc = 0;
    stall_cnt = 0; rsp_cnt = 0; rsp_base = 0;
    status_dflt = 8'h01; rx_val = 8'h00;
    HRESETn = 1'b0; req_valid = 1'b0; req_rnw = 1'b0; req_dev = 7'h0;
    req_reg = 8'h0; req_wdata = 8'h0; rsp_ready = 1'b1;
    PREADY = 1'b1; PRDATA = 32'h0;

    repeat (3) @(posedge HCLK);
    #1;
    reset_outputs_zero("reset_state");

    exp_w(12'h000, 32'h0000_0063);
    exp_w(12'h004, 32'h0000_0080);
    HRESETn = 1'b1;
    wait_ready();
    chk("init_writes_before_ready", 64'(apb_done), 64'd2);

    // Write dev 0x50 reg 0x12 data 0xA5, all ACK
    exp_step(1'b1, 8'hA0, 8'h91);
    exp_step(1'b1, 8'h12, 8'h11);
    exp_step(1'b1, 8'hA5, 8'h51);
    exp_rsp.push_back('{rdata: 8'h00, err: 2'b00});
    do_req(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp("write");

    // Read dev 0x50 reg 0x12, RX 0x5A, response held while rsp_ready low
    rx_val = 8'h5A;
    exp_step(1'b1, 8'hA0, 8'h91);
    exp_step(1'b1, 8'h12, 8'h11);
    exp_step(1'b1, 8'hA1, 8'h91);
    exp_step(1'b0, 8'h00, 8'h69);
    exp_r(12'h00C);
    exp_rsp.push_back('{rdata: 8'h5A, err: 2'b00});
    rsp_ready = 1'b0;
    do_req(1'b1, 7'h50, 8'h12, 8'h00);
    for (int n = 0; n < 3000 && !rsp_valid; n++) begin
      @(posedge HCLK); #1;
    end
    repeat (3) @(posedge HCLK);
    #1;
    chk("rsp_held", {rsp_valid, req_ready, rsp_rdata, rsp_err}, {1'b1, 1'b0, 8'h5A, 2'b00});
    rsp_ready = 1'b1;
    wait_rsp("read");

    // Address NACK at first IF
    status_q.push_back(8'h81);
    exp_w(12'h008, 32'hA0);
    exp_w(12'h010, 32'h91);
    exp_r(12'h014);
    exp_w(12'h010, 32'h41);
    exp_r(12'h014);
    exp_w(12'h010, 32'h01);
    exp_rsp.push_back('{rdata: 8'h00, err: 2'b01});
    do_req(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp("nack");

    // Arbitration lost during step 2: no STO
    status_q.push_back(8'h01);
    status_q.push_back(8'h21);
    exp_step(1'b1, 8'hA0, 8'h91);
    exp_step(1'b1, 8'h12, 8'h11);
    exp_rsp.push_back('{rdata: 8'h00, err: 2'b10});
    do_req(1'b0, 7'h50, 8'h12, 8'h33);
    wait_rsp("arb_lost");

    // PREADY low for 5 cycles on the first transfer of a write
    max_acc = 0;
    stall_cnt = 5;
    exp_step(1'b1, 8'h78, 8'h91);
    exp_step(1'b1, 8'h07, 8'h11);
    exp_step(1'b1, 8'hFF, 8'h51);
    exp_rsp.push_back('{rdata: 8'h00, err: 2'b00});
    do_req(1'b0, 7'h3C, 8'h07, 8'hFF);
    wait_rsp("stall");
    chk("stall_access_cycles", 64'(max_acc), 64'd6);

    // IF never set: 4 STATUS reads then STO, timeout
    status_dflt = 8'h00;
    exp_w(12'h008, 32'hA0);
    exp_w(12'h010, 32'h91);
    for (int i = 0; i < 4; i++) exp_r(12'h014);
    exp_w(12'h010, 32'h41);
    exp_rsp.push_back('{rdata: 8'h00, err: 2'b11});
    do_req(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp("timeout");

    // Reset asserted while polling
    exp_w(12'h008, 32'hA0);
    exp_w(12'h010, 32'h91);
    for (int i = 0; i < 4; i++) exp_r(12'h014);
    exp_w(12'h010, 32'h41);
    do_req(1'b0, 7'h50, 8'h12, 8'hA5);
    begin
      int n = 0;
      while (!(PSEL && PADDR == 12'h014) && n < 500) begin
        @(negedge HCLK);
        n++;
      end
      chk("reached_poll", {PSEL, PADDR}, {1'b1, 12'h014});
    end
    #1;
    HRESETn = 1'b0;
    #1;
    reset_outputs_zero("midpoll_reset_state");
    exp_apb.delete();
    status_q.delete();
    status_dflt = 8'h01;
    stall_cnt = 0;
    acc_len = 0;
    apb_done = 0;
    @(posedge HCLK); #1;
    exp_w(12'h000, 32'h0000_0063);
    exp_w(12'h004, 32'h0000_0080);
    HRESETn = 1'b1;
    wait_ready();
    chk("reinit_writes_before_ready", 64'(apb_done), 64'd2);

    // Read after re-init: dev 0x21 reg 0xF0, RX 0xC3
    rx_val = 8'hC3;
    exp_step(1'b1, 8'h42, 8'h91);
    exp_step(1'b1, 8'hF0, 8'h11);
    exp_step(1'b1, 8'h43, 8'h91);
    exp_step(1'b0, 8'h00, 8'h69);
    exp_r(12'h00C);
    exp_rsp.push_back('{rdata: 8'hC3, err: 2'b00});
    do_req(1'b1, 7'h21, 8'hF0, 8'h00);
    wait_rsp("read_after_reset");

    chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
